// File: rtl/fifo_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fifo_pkg : shared FSM state type and sizing helper              |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_serial_tx_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fifo_serial_tx_if : FIFO-side handshake and serial line bundle  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface fifo_serial_tx_if #(
    parameter int WIDTH = 8
) ();
    logic             enable;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             tx;
    logic             busy;
    logic             frame_done;

    modport master (
        input  enable, fifo_data, fifo_empty,
        output fifo_pop, tx, busy, frame_done
    );

    modport slave (
        output enable, fifo_data, fifo_empty,
        input  fifo_pop, tx, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/fifo_baud_gen.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fifo_baud_gen : bit-period counter, pulses bit_end on last clk  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module fifo_baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_end = !clear && (cnt == LAST);
endmodule
`default_nettype wire

// File: rtl/fifo_serial_tx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fifo_serial_tx : pops words from a show-ahead FIFO and sends    |
// | them as start/LSB-first data/stop frames. Rev 1.0               |
// +-----------------------------------------------------------------+
module fifo_serial_tx
    import fifo_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_serial_tx_if.master bus
);
    localparam int            BW       = clog2_min1(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic             tx_q, tx_n;
    logic             bit_end;
    logic             launch_ok;
    logic             pop;
    logic             done;

    fifo_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == IDLE),
        .bit_end(bit_end)
    );

    // rst_n gating keeps the pop quiet while reset holds the FSM in IDLE
    assign launch_ok = rst_n && bus.enable && !bus.fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            tx_q    <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        tx_n      = tx_q;
        pop       = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (launch_ok) begin
                    pop     = 1'b1;
                    shreg_n = bus.fifo_data;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    tx_n      = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_n   = STOP;
                        bit_cnt_n = '0;
                        tx_n      = 1'b1;
                    end else begin
                        shreg_n   = shreg >> 1;
                        bit_cnt_n = bit_cnt + BW'(1);
                        tx_n      = shreg_n[0];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    done = 1'b1;
                    if (launch_ok) begin
                        pop     = 1'b1;
                        shreg_n = bus.fifo_data;
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    assign bus.fifo_pop   = pop;
    assign bus.tx         = tx_q;
    assign bus.busy       = (state != IDLE);
    assign bus.frame_done = done;
endmodule
`default_nettype wire

// File: doc/fifo_serial_tx.md
FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit period (legal range 2..65535).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  permits starting a new frame; sampled only at frame boundaries.
REQ-006 SHALL have port fifo_data  input  WIDTH  show-ahead head-of-queue word from the upstream FIFO.
REQ-007 SHALL have port fifo_empty  input  1  upstream FIFO holds no words.
REQ-008 SHALL have port fifo_pop  output  1  single-cycle pop request to the upstream FIFO.
REQ-009 SHALL have port tx  output  1  registered serial line output; idle high.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse on the last stop-bit cycle.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-013 SHALL leave IDLE only when enable=1 and fifo_empty=0, going to START.
REQ-014 SHALL, on the launch cycle T, assert fifo_pop combinationally for exactly that cycle and capture fifo_data into the shift register on the same edge.
REQ-015 SHALL never assert fifo_pop while fifo_empty=1.
REQ-016 SHALL drive tx=0 for cycles T+1..T+C, where C=CLKS_PER_BIT.
REQ-017 SHALL send data LSB first, bit k on cycles T+(k+1)C+1..T+(k+2)C.
REQ-018 SHALL drive tx=1 for the stop bit on cycles T+(WIDTH+1)C+1..T+(WIDTH+2)C, giving a frame length of exactly (WIDTH+2)*C cycles.
REQ-019 SHALL use a baud counter of width $clog2(CLKS_PER_BIT) that counts 0..C-1 and wraps to 0 at each bit boundary.
REQ-020 SHALL use a bit counter of width $clog2(WIDTH) (minimum 1) that advances only in DATA and leaves DATA after bit WIDTH-1.
REQ-021 SHALL, on the last STOP cycle, pulse frame_done and relaunch back-to-back (pop and load, START next cycle) if enable=1 and fifo_empty=0; otherwise it SHALL return to IDLE.
REQ-022 SHALL ignore enable deassertion mid-frame; the current frame completes.
REQ-023 SHALL ignore fifo_data and fifo_empty changes mid-frame; the shift register is the only data source after launch.
REQ-024 SHALL hold tx=1 in IDLE.

Reset
REQ-025 SHALL, while rst_n=0, immediately force state=IDLE, tx=1, fifo_pop=0, busy=0, frame_done=0, and clear both counters and the shift register.
REQ-026 SHALL abandon any frame in progress on reset, with no pop issued.
REQ-027 SHALL, after rst_n deasserts, launch no earlier than the first rising edge with enable=1 and fifo_empty=0.

Structure
REQ-028 SHALL take the state enum type (IDLE/START/DATA/STOP) from the shared package fifo_pkg.
REQ-029 SHALL place the baud-period counter in one sub-module, fifo_baud_gen, which outputs a bit_end pulse and is held cleared while the FSM is in IDLE.
REQ-030 SHALL register tx; fifo_pop, busy and frame_done MAY be decoded from state.

Verification
REQ-031 SHALL verify single frame, WIDTH=8, C=4: 0xA5 queued, enable=1 -> one pop pulse; tx per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1; frame_done at cycle T+40.
REQ-032 SHALL verify back-to-back: 0x00 then 0xFF queued -> second pop on cycle T+40, second start bit at T+41, no idle gap; exactly 2 pops total.
REQ-033 SHALL verify empty/disabled: fifo_empty=1 for 100 cycles -> fifo_pop never high, tx=1, busy=0; same result with enable=0 and a non-empty FIFO.
REQ-034 SHALL verify enable drop: enable falls at T+10 during 0x3C -> full 40-cycle frame completes, then IDLE with no further pop.
REQ-035 SHALL verify reset mid-frame: rst_n low at T+17 -> tx=1 and busy=0 the same cycle; after release with FIFO non-empty, a fresh frame starts with a single pop.
REQ-036 SHALL verify parameter corner: WIDTH=5, C=2, word 0x13 -> frame of 14 cycles; tx per 2-cycle bit = 0,1,1,0,0,1,1.
